// File: rtl/obi_pkg.sv
// OBI bus configuration record and the default request/response structs
// shared by the memory responder and its bench.
package obi_pkg;

  typedef struct packed {
    int unsigned DataWidth;
    int unsigned AddrWidth;
    int unsigned IdWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t ObiDefaultConfig = '{
    DataWidth: 32'd32,
    AddrWidth: 32'd32,
    IdWidth:   32'd4,
    UseRReady: 1'b1
  };

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        rready;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/obi_mem_responder.sv
// OBI responder: word-addressed register memory with fixed-latency, in-order, credit-limited responses.
// Define OBI_MEM_RESPONDER_RANGE_ERR_EN to flag accesses beyond the array with err=1 instead of wrapping.
module obi_mem_responder #(
  parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
  parameter type               obi_req_t   = obi_pkg::obi_req_t,
  parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
  parameter int unsigned       NumWords    = 256,
  parameter int unsigned       Latency     = 1,
  parameter int unsigned       NumMaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);
  localparam int unsigned DW   = ObiCfg.DataWidth;
  localparam int unsigned IW   = ObiCfg.IdWidth;
  localparam int unsigned NB   = DW / 8;
  localparam int unsigned OffW = $clog2(NB);
  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic          err;
  } ent_t;

  logic [DW-1:0]   r_mem  [NumWords];
  ent_t            r_fifo [NumMaxTrans];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_fcnt;
  logic [CntW-1:0] r_cnt;

  logic            w_gnt;
  logic            w_hs;
  logic            w_rready;
  logic            w_rvalid;
  logic            w_pop;
  logic            w_push;
  logic            w_err;
  logic [IdxW-1:0] w_idx;
  ent_t            w_ent;
  ent_t            w_push_ent;
  logic            w_unused;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(NumMaxTrans - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign w_unused = ^obi_req_i;
  assign w_idx    = obi_req_i.addr[OffW +: IdxW];

`ifdef OBI_MEM_RESPONDER_RANGE_ERR_EN
  assign w_err = |(obi_req_i.addr >> (OffW + IdxW));
`else
  assign w_err = 1'b0;
`endif

  assign w_rready = ObiCfg.UseRReady ? obi_req_i.rready : 1'b1;
  // Grant only on a free credit; a retire in the same cycle does not bypass.
  assign w_gnt    = obi_req_i.req && (r_cnt < CntW'(NumMaxTrans));
  assign w_hs     = w_gnt;
  assign w_rvalid = (r_fcnt != '0);
  assign w_pop    = w_rvalid && w_rready;

  // Response entry captured at the handshake edge
  always_comb begin
    w_ent.id  = obi_req_i.aid;
    w_ent.err = w_err;
    if (obi_req_i.we || w_err) begin
      w_ent.data = '0;
    end else begin
      w_ent.data = r_mem[w_idx];
    end
  end

  // Byte-enabled array write; the array itself carries no reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < int'(NB); b++) begin
      if (w_hs && obi_req_i.we && !w_err && obi_req_i.be[b]) begin
        r_mem[w_idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
      end
    end
  end

  if (Latency > 1) begin : g_pipe
    logic [Latency-2:0] r_pv;
    ent_t               r_pd [Latency-1];

    // Delay line of Latency-1 stages ahead of the response FIFO
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_pv <= '0;
        for (int i = 0; i < int'(Latency) - 1; i++) r_pd[i] <= '0;
      end else begin
        r_pv[0] <= w_hs;
        r_pd[0] <= w_ent;
        for (int i = 1; i < int'(Latency) - 1; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pd[i] <= r_pd[i-1];
        end
      end
    end

    assign w_push     = r_pv[Latency-2];
    assign w_push_ent = r_pd[Latency-2];
  end else begin : g_nopipe
    assign w_push     = w_hs;
    assign w_push_ent = w_ent;
  end

  // Response FIFO; its head register drives the R channel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
      for (int i = 0; i < int'(NumMaxTrans); i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= w_push_ent;
        r_wptr         <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // Outstanding-transaction credit counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Response port assembly
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = w_gnt;
    obi_rsp_o.rvalid = w_rvalid;
    if (w_rvalid) begin
      obi_rsp_o.rdata = r_fifo[r_rptr].data;
      obi_rsp_o.rid   = r_fifo[r_rptr].id;
      obi_rsp_o.err   = r_fifo[r_rptr].err;
    end else begin
      obi_rsp_o.rdata = '0;
      obi_rsp_o.rid   = '0;
      obi_rsp_o.err   = 1'b0;
    end
  end

  a_latency_range: assert property (@(posedge clk_i) (Latency >= 1) && (Latency <= 4));
  a_words_pow2:    assert property (@(posedge clk_i) (NumWords & (NumWords - 1)) == 0);
  a_cnt_bound:     assert property (@(posedge clk_i) disable iff (rst_i) r_cnt <= CntW'(NumMaxTrans));
  a_no_push_full:  assert property (@(posedge clk_i) disable iff (rst_i)
                                    w_push |-> (r_fcnt < CntW'(NumMaxTrans)));

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: directed and random traffic on a Latency=1 and a Latency=3 instance,
// checked against a transaction-level model (byte memory, expected-response queue, ready cycles).
module tb_obi_mem_responder;

`ifdef OBI_MEM_RESPONDER_RANGE_ERR_EN
  localparam bit RangeEn = 1'b1;
`else
  localparam bit RangeEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst1, rst3;
  obi_pkg::obi_req_t r1, r3;
  obi_pkg::obi_rsp_t rsp1, rsp3;

  obi_mem_responder #(.NumWords(256), .Latency(1), .NumMaxTrans(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .obi_req_i(r1), .obi_rsp_o(rsp1));
  obi_mem_responder #(.NumWords(256), .Latency(3), .NumMaxTrans(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .obi_req_i(r3), .obi_rsp_o(rsp3));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model state, index 0 = Latency-1 instance, 1 = Latency-3 instance
  logic [31:0] mem_m  [2][256];
  logic [31:0] e_data [2][64];
  logic [3:0]  e_id   [2][64];
  logic        e_err  [2][64];
  int          e_rdy  [2][64];
  int          hd [2];
  int          tl [2];
  int          last_hs [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int d, input obi_pkg::obi_req_t rq, input obi_pkg::obi_rsp_t rs,
                     input logic rst, input int maxt, input int lat);
    int slot, outst, w;
    logic ev, eg, oor;
    if (rst) begin
      hd[d] = 0;
      tl[d] = 0;
    end else begin
      outst = tl[d] - hd[d];
      slot  = hd[d] % 64;
      ev    = (outst > 0) && (e_rdy[d][slot] <= cyc);
      chk($sformatf("d%0d.rvalid@%0d", d, cyc), 64'(rs.rvalid), 64'(ev));
      if (ev) begin
        chk($sformatf("d%0d.rdata@%0d", d, cyc), 64'(rs.rdata), 64'(e_data[d][slot]));
        chk($sformatf("d%0d.rid@%0d", d, cyc), 64'(rs.rid), 64'(e_id[d][slot]));
        chk($sformatf("d%0d.err@%0d", d, cyc), 64'(rs.err), 64'(e_err[d][slot]));
        if (rq.rready) hd[d]++;
      end
      eg = rq.req && (outst < maxt);
      chk($sformatf("d%0d.gnt@%0d", d, cyc), 64'(rs.gnt), 64'(eg));
      if (eg) begin
        slot = tl[d] % 64;
        oor  = RangeEn && (rq.addr >= 32'h400);
        w    = int'((rq.addr >> 2) % 32'd256);
        e_rdy[d][slot]  = cyc + lat;
        e_id[d][slot]   = rq.aid;
        e_err[d][slot]  = oor;
        e_data[d][slot] = (rq.we || oor) ? 32'h0 : mem_m[d][w];
        if (rq.we && !oor) begin
          for (int b = 0; b < 4; b++)
            if (rq.be[b]) mem_m[d][w][8*b +: 8] = rq.wdata[8*b +: 8];
        end
        tl[d]++;
        last_hs[d] = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, r1, rsp1, rst1, 2, 1);
    mon(1, r3, rsp3, rst3, 4, 3);
  end

  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [3:0] id, input bit rnd_rdy);
    obi_pkg::obi_req_t s;
    int n;
    s = '0;
    s.req = 1'b1; s.we = we; s.addr = addr; s.be = be; s.wdata = wd; s.aid = id;
    if (d == 0) begin s.rready = r1.rready; r1 = s; end
    else        begin s.rready = r3.rready; r3 = s; end
    n = 0;
    @(negedge clk);
    while (!((d == 0) ? rsp1.gnt : rsp3.gnt) && n < 300) begin
      @(posedge clk); #1;
      if (rnd_rdy) begin
        if (d == 0) r1.rready = 1'($urandom_range(0, 1));
        else        r3.rready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk($sformatf("d%0d.gnt_timeout", d), 64'((d == 0) ? rsp1.gnt : rsp3.gnt), 64'd1);
    @(posedge clk); #1;
    if (d == 0) r1.req = 1'b0;
    else        r3.req = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int n;
    n = 0;
    while (tl[d] != hd[d] && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("d%0d.drain_pending", d), 64'(tl[d] - hd[d]), 64'd0);
  endtask

  int t_rr, t_first;
  logic [31:0] wexp;

  initial begin
    r1 = '0; r3 = '0;
    r1.rready = 1'b1; r3.rready = 1'b1;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.gnt",    64'(rsp1.gnt),    64'd0);
    chk("reset.rvalid", 64'(rsp1.rvalid), 64'd0);
    chk("reset.rdata",  64'(rsp1.rdata),  64'd0);
    chk("reset.rid",    64'(rsp1.rid),    64'd0);
    chk("reset.err",    64'(rsp1.err),    64'd0);
    rst1 = 1'b0; rst3 = 1'b0;

    for (int i = 0; i < 16; i++) issue(0, 1'b1, 32'(i * 4), 4'hF, $urandom, 4'(i), 1'b0);

    // write then read back with one-cycle latency
    issue(0, 1'b1, 32'h14, 4'hF, 32'hDEADBEEF, 4'd3, 1'b0);
    issue(0, 1'b0, 32'h14, 4'h0, 32'h0, 4'd5, 1'b0);
    chk("rd14.rvalid", 64'(rsp1.rvalid), 64'd1);
    chk("rd14.rdata",  64'(rsp1.rdata),  64'hDEADBEEF);
    chk("rd14.rid",    64'(rsp1.rid),    64'd5);
    chk("rd14.err",    64'(rsp1.err),    64'd0);

    // byte enables
    issue(0, 1'b1, 32'h0, 4'hF, 32'h11223344, 4'd1, 1'b0);
    issue(0, 1'b1, 32'h0, 4'b0010, 32'h0000AA00, 4'd2, 1'b0);
    issue(0, 1'b0, 32'h0, 4'h0, 32'h0, 4'd4, 1'b0);
    chk("be.rdata", 64'(rsp1.rdata), 64'h1122AA44);

    // out-of-range read
    issue(0, 1'b0, 32'h400, 4'h0, 32'h0, 4'd7, 1'b0);
    wexp = RangeEn ? 32'h0 : 32'h1122AA44;
    chk("range.rdata", 64'(rsp1.rdata), 64'(wexp));
    chk("range.err",   64'(rsp1.err),   64'(RangeEn));
    wait_drain(0);

    // backpressure: two credits, third request waits for the first retire
    r1.rready = 1'b0;
    fork
      begin
        issue(0, 1'b0, 32'h4, 4'h0, 32'h0, 4'd1, 1'b0);
        issue(0, 1'b0, 32'h8, 4'h0, 32'h0, 4'd2, 1'b0);
        issue(0, 1'b0, 32'hC, 4'h0, 32'h0, 4'd3, 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp.gnt_low",  64'(rsp1.gnt),    64'd0);
        chk("bp.rvalid",   64'(rsp1.rvalid), 64'd1);
        t_rr = cyc;
        r1.rready = 1'b1;
      end
    join
    chk("bp.third_gnt_cycle", 64'(last_hs[0]), 64'(t_rr + 1));
    wait_drain(0);

    // streaming 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b0, 32'(i * 4), 4'h0, 32'h0, 4'(i), 1'b0);
      if (i == 0) t_first = last_hs[0];
    end
    chk("stream.cycles", 64'(last_hs[0] - t_first), 64'd15);
    wait_drain(0);

    // random traffic with random rready
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 7) == 0) a = a + 32'h400;
      r1.rready = 1'($urandom_range(0, 1));
      issue(0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
            4'($urandom_range(0, 15)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    r1.rready = 1'b1;
    wait_drain(0);

    // reset with responses in flight on the Latency=3 instance
    issue(1, 1'b1, 32'h0, 4'hF, 32'hCAFE0001, 4'd1, 1'b0);
    wait_drain(1);
    r3.rready = 1'b0;
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 4'd2, 1'b0);
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 4'd3, 1'b0);
    @(posedge clk); #1;
    chk("rst3.pre_rvalid", 64'(rsp3.rvalid), 64'd1);
    rst3 = 1'b1;
    #1;
    chk("rst3.rvalid_now", 64'(rsp3.rvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst3 = 1'b0;
    r3.rready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    r3.req = 1'b1; r3.we = 1'b0; r3.addr = 32'h0; r3.aid = 4'd9;
    #1;
    chk("rst3.first_gnt", 64'(rsp3.gnt), 64'd1);
    issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 4'd9, 1'b0);
    wait_drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
